// File: rtl/id_inst_queue_pkg.sv
// Shared defaults for the IF->ID instruction queue.
// IQ_ENTRY_WD is the width of one entry as seen by the IF/ID bus (pc, inst, inst_ok).
package id_inst_queue_pkg;

    localparam int IQ_DEPTH    = 4;
    localparam int IQ_PC_WD    = 32;
    localparam int IQ_INST_WD  = 32;
    localparam int IQ_ENTRY_WD = IQ_PC_WD + IQ_INST_WD + 1;

endpackage

// File: rtl/iq_ram.sv
// Entry storage for the instruction queue: separate pc and inst write ports, one async read.
// Data-only array; validity is tracked by the owner, so there is no reset here.
module iq_ram
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int PC_WD   = IQ_PC_WD,
    parameter int INST_WD = IQ_INST_WD
) (
    input  logic                     clk,
    input  logic                     pc_we,
    input  logic [$clog2(DEPTH)-1:0] pc_waddr,
    input  logic [PC_WD-1:0]         pc_wdata,
    input  logic                     inst_we,
    input  logic [$clog2(DEPTH)-1:0] inst_waddr,
    input  logic [INST_WD-1:0]       inst_wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PC_WD-1:0]         rd_pc,
    output logic [INST_WD-1:0]       rd_inst
);

    logic [PC_WD-1:0]   pc_mem   [DEPTH];
    logic [INST_WD-1:0] inst_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (pc_we) begin
            pc_mem[pc_waddr] <= pc_wdata;
        end
        if (inst_we) begin
            inst_mem[inst_waddr] <= inst_wdata;
        end
    end

    assign rd_pc   = pc_mem[raddr];
    assign rd_inst = inst_mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// In-order instruction queue between IF and ID with a same-cycle bypass of the SRAM
// response, so an empty queue adds no latency to decode.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int PC_WD   = IQ_PC_WD,
    parameter int INST_WD = IQ_INST_WD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_ce,
    input  logic [PC_WD-1:0]           req_pc,
    input  logic [INST_WD-1:0]         inst_sram_rdata,
    output logic                       if_stallreq,
    output logic                       id_valid,
    output logic [PC_WD-1:0]           id_pc,
    output logic [INST_WD-1:0]         id_inst,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   pending_idx;
    logic               pending;
    logic [DEPTH-1:0]   inst_ok;
    logic               accept;
    logic               capture;
    logic               pop;
    logic               head_ready;
    logic [PC_WD-1:0]   rd_pc;
    logic [INST_WD-1:0] rd_inst;

    assign if_stallreq = (occupancy == OCC_W'(DEPTH));
    assign accept      = req_ce & ~if_stallreq & ~flush & ~rst;
    assign capture     = pending & ~flush & ~rst;

    // Head is presentable either from storage or straight off the SRAM bus.
    assign head_ready = inst_ok[head] | (pending & (pending_idx == head));
    assign id_valid   = (occupancy != '0) & head_ready & ~flush;
    assign pop        = id_valid & id_ready;

    assign id_pc   = id_valid ? rd_pc : '0;
    assign id_inst = !id_valid     ? '0 :
                     inst_ok[head] ? rd_inst : inst_sram_rdata;

    iq_ram #(
        .DEPTH  (DEPTH),
        .PC_WD  (PC_WD),
        .INST_WD(INST_WD)
    ) u_ram (
        .clk       (clk),
        .pc_we     (accept),
        .pc_waddr  (tail),
        .pc_wdata  (req_pc),
        .inst_we   (capture),
        .inst_waddr(pending_idx),
        .inst_wdata(inst_sram_rdata),
        .raddr     (head),
        .rd_pc     (rd_pc),
        .rd_inst   (rd_inst)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head        <= '0;
            tail        <= '0;
            pending     <= 1'b0;
            pending_idx <= '0;
            inst_ok     <= '0;
            occupancy   <= '0;
        end else begin
            pending <= accept;
            if (accept) begin
                tail        <= tail + PTR_W'(1);
                pending_idx <= tail;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (accept && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (pop && !accept) begin
                occupancy <= occupancy - OCC_W'(1);
            end
            // Later writes win: a bypassed pop frees the slot its capture just filled.
            if (capture) begin
                inst_ok[pending_idx] <= 1'b1;
            end
            if (pop) begin
                inst_ok[head] <= 1'b0;
            end
            if (accept) begin
                inst_ok[tail] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed scenarios plus random traffic, all checked against
// a queue-of-entries reference model updated once per clock.
module tb_id_inst_queue;

    localparam int DEPTH   = 4;
    localparam int PC_WD   = 32;
    localparam int INST_WD = 32;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          ok;
    } entry_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               req_ce = 1'b0;
    logic [PC_WD-1:0]   req_pc = '0;
    logic [INST_WD-1:0] inst_sram_rdata = '0;
    logic               if_stallreq;
    logic               id_valid;
    logic [PC_WD-1:0]   id_pc;
    logic [INST_WD-1:0] id_inst;
    logic               id_ready = 1'b0;
    logic [OCC_W-1:0]   occupancy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    entry_t      q[$];
    bit          pend = 0;
    bit          known = 0;
    bit          last_acc = 0;
    logic [31:0] last_pc, last_inst;
    logic        last_stall, last_valid;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    always #5 clk = ~clk;

    id_inst_queue #(
        .DEPTH  (DEPTH),
        .PC_WD  (PC_WD),
        .INST_WD(INST_WD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_ce         (req_ce),
        .req_pc         (req_pc),
        .inst_sram_rdata(inst_sram_rdata),
        .if_stallreq    (if_stallreq),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_ready       (id_ready),
        .occupancy      (occupancy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic step(input bit r, input bit f, input bit rc, input logic [31:0] pc,
                        input logic [31:0] rd, input bit rdy);
        bit          e_valid, e_stall, acc, pp;
        logic [31:0] e_pc, e_inst;
        entry_t      e;
        @(negedge clk);
        rst = r; flush = f; req_ce = rc; req_pc = pc; inst_sram_rdata = rd; id_ready = rdy;
        #1;
        e_stall = (q.size() == DEPTH);
        e_valid = 0;
        e_pc    = '0;
        e_inst  = '0;
        if (!f && q.size() > 0 && (q[0].ok || (pend && q.size() == 1))) begin
            e_valid = 1;
            e_pc    = q[0].pc;
            e_inst  = q[0].ok ? q[0].inst : rd;
        end
        if (known) begin
            check_eq("id_valid", id_valid, e_valid);
            check_eq("id_pc", id_pc, e_pc);
            check_eq("id_inst", id_inst, e_inst);
            check_eq("if_stallreq", if_stallreq, e_stall);
            check_eq("occupancy", occupancy, q.size());
        end
        last_pc = id_pc; last_inst = id_inst; last_stall = if_stallreq; last_valid = id_valid;
        if (id_valid === 1'b1 && rdy) begin
            pop_pc.push_back(id_pc);
            pop_inst.push_back(id_inst);
        end
        @(posedge clk);
        acc = 0;
        if (r || f) begin
            q.delete();
            pend = 0;
        end else begin
            acc = rc && !e_stall;
            pp  = e_valid && rdy;
            if (pend) begin
                e = q[q.size()-1];
                e.ok = 1;
                e.inst = rd;
                q[q.size()-1] = e;
            end
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.pc = pc; e.inst = '0; e.ok = 0;
                q.push_back(e);
            end
            pend = acc;
        end
        last_acc = acc;
        if (r) known = 1;
    endtask

    initial begin
        int i, guard;
        bit tog;

        // Reset with random inputs on the other pins
        for (int k = 0; k < 2; k++)
            step(1, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        step(0, 0, 0, 0, $urandom, 0);
        check_eq("rst_valid", last_valid, 0);
        check_eq("rst_stall", last_stall, 0);

        // Passthrough
        step(0, 0, 1, 32'hBFC0_0000, $urandom, 1);
        step(0, 0, 0, 0, 32'h3C01_0001, 1);
        check_eq("pass_valid", last_valid, 1);
        check_eq("pass_pc", last_pc, 32'hBFC0_0000);
        check_eq("pass_inst", last_inst, 32'h3C01_0001);
        step(0, 0, 0, 0, $urandom, 1);

        // Fill and back-pressure, fifth request ignored
        pop_pc.delete(); pop_inst.delete();
        step(0, 0, 1, 32'h0, $urandom, 0);
        step(0, 0, 1, 32'h4, 32'h11, 0);
        step(0, 0, 1, 32'h8, 32'h22, 0);
        step(0, 0, 1, 32'hC, 32'h33, 0);
        step(0, 0, 1, 32'h10, 32'h44, 0);
        check_eq("fill_stall", last_stall, 1);
        step(0, 0, 0, 0, $urandom, 1);
        check_eq("stall_at_first_pop", last_stall, 1);
        step(0, 0, 0, 0, $urandom, 1);
        check_eq("stall_after_pop", last_stall, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, $urandom, 1);
        check_eq("fill_pops", pop_pc.size(), 4);
        for (int k = 0; k < 4 && k < pop_pc.size(); k++) begin
            check_eq("fill_pc", pop_pc[k], 4 * k);
            check_eq("fill_inst", pop_inst[k], 32'h11 * (k + 1));
        end

        // Flush with two stored entries and one response in flight
        pop_inst.delete();
        step(0, 0, 1, 32'h100, $urandom, 0);
        step(0, 0, 1, 32'h104, 32'hA0, 0);
        step(0, 0, 1, 32'h108, 32'hA4, 0);
        step(0, 1, 1, 32'h10C, 32'hA8, 1);
        step(0, 0, 0, 0, 32'hDEAD_BEEF, 1);
        check_eq("flush_valid", last_valid, 0);
        step(0, 0, 0, 0, 32'hDEAD_BEEF, 1);
        check_eq("flush_no_pop", pop_inst.size(), 0);

        // Wrap and ordering with id_ready toggling
        pop_pc.delete();
        i = 0; guard = 0; tog = 1;
        while (i < 10 && guard < 100) begin
            step(0, 0, 1, 32'(4 * i), $urandom, tog);
            if (last_acc) i++;
            tog = !tog;
            guard++;
        end
        check_eq("wrap_issued", i, 10);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, $urandom, 1);
        check_eq("wrap_pops", pop_pc.size(), 10);
        for (int k = 0; k < 10 && k < pop_pc.size(); k++) check_eq("wrap_pc", pop_pc[k], 4 * k);

        // Mid-operation reset with full queue and pending response
        for (int k = 0; k < 4; k++) step(0, 0, 1, 32'(32'h200 + 4 * k), $urandom, 0);
        step(1, 0, 1, 32'h300, $urandom, 1);
        step(0, 0, 0, 0, $urandom, 1);
        check_eq("mrst_valid", last_valid, 0);
        check_eq("mrst_stall", last_stall, 0);
        step(0, 0, 1, 32'h400, $urandom, 1);
        step(0, 0, 0, 0, 32'h1234_5678, 1);
        check_eq("mrst_pass_pc", last_pc, 32'h400);
        check_eq("mrst_pass_inst", last_inst, 32'h1234_5678);

        // Random traffic
        for (int k = 0; k < 3000; k++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 2) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_inst_queue.md
# id_inst_queue

Parametrised instruction queue between IF and ID that replaces the single-entry stall buffer in front of decode. It records every accepted fetch (pc), captures the instruction SRAM read data one cycle later, and presents entries in order to decode under a valid/ready handshake. It also provides a bypass path, so the no-stall pipeline timing is unchanged. It absorbs up to DEPTH outstanding fetches, back-pressures IF when full, and discards everything, including the in-flight SRAM response, on a branch/exception flush.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- PC_WD, 32: pc width.
- INST_WD, 32: instruction width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  redirect; discards all entries, the pending response, and any same-cycle request.
- req_ce  in  1  IF issues a fetch this cycle (same cycle as inst SRAM enable).
- req_pc  in  PC_WD  pc of that fetch.
- inst_sram_rdata  in  INST_WD  SRAM data; valid the cycle after an accepted req_ce.
- if_stallreq  out  1  IF must hold; high when occupancy == DEPTH.
- id_valid  out  1  head entry available to decode.
- id_pc  out  PC_WD  head pc.
- id_inst  out  INST_WD  head instruction.
- id_ready  in  1  decode consumes the head this cycle (not stalled).
- occupancy  out  $clog2(DEPTH+1)  allocated entries, including the pending one.

## Operation
- Storage: DEPTH entries of {pc, inst, inst_ok}, plus head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Accept: a request is accepted when req_ce & ~if_stallreq & ~flush.
  - Writes req_pc at tail and clears inst_ok.
  - Advances tail and records pending_idx = tail, pending = 1.
- Capture: the cycle after an accept, inst_sram_rdata is written to entry pending_idx, inst_ok is set, and pending clears unless a new accept occurs in the same cycle.
- Head present: id_valid = head allocated & (inst_ok | (pending & pending_idx == head)) & ~flush.
  - id_inst = inst_ok ? stored inst : inst_sram_rdata (bypass).
  - When id_valid = 0, id_pc and id_inst drive 0.
- Pop: id_valid & id_ready advances head. A bypassed pop still completes the capture, so the entry is freed and nothing is retained.
- Occupancy: next value = occupancy + accept − pop. Simultaneous accept and pop leaves it unchanged.
- Full: if_stallreq = (occupancy == DEPTH), derived from registers only (no combinational path from req_ce or id_ready).
  - A req_ce while if_stallreq is high is a protocol error; it is ignored with no state change.
  - A pop in the full cycle frees space, but if_stallreq only drops the following cycle.
- Empty: id_valid = 0; pop is impossible.
- Flush: the next state is pointers 0, occupancy 0, pending 0, all inst_ok 0. The next cycle's inst_sram_rdata is ignored. Flush overrides accept, pop and capture in the same cycle.
- Reset: same state as flush. All outputs read 0: id_valid, id_pc, id_inst, if_stallreq, occupancy.

## Timing
- Fetch at cycle t, queue empty, id_ready=1: id_valid at t+1 with id_inst = inst_sram_rdata (zero added latency). Occupancy is 1 during t+1 and 0 at t+2.
- Stored entries are presented from registers; pop takes effect at the clock edge.
- Sustained throughput is one instruction per cycle, provided occupancy < DEPTH.
- Flush at t: id_valid = 0 at t (gated) and at t+1. A new fetch is accepted from t+1.
- Reset is effective at the first rising edge with rst=1. A mid-operation reset drops all content.

## Structure
- lib/defines.vh gains `IQ_DEPTH` (default 4) and `IQ_ENTRY_WD` (PC_WD+INST_WD+1). The IF/ID bus widths are rederived from these.
- One sub-module, iq_ram: a DEPTH×(PC_WD+INST_WD) register array with one write port for pc, one for inst, and one async read port.
- Pointer, occupancy and pending logic stay in id_inst_queue.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, occupancy 0, if_stallreq 0.
- Passthrough: req_ce pc=0xBFC00000 at t, rdata=0x3C010001 at t+1, id_ready=1 -> at t+1 id_valid=1, id_pc=0xBFC00000, id_inst=0x3C010001; occupancy 0 at t+2.
- Fill/backpressure: id_ready=0, accept pcs 0x0,0x4,0x8,0xC with rdata 0x11,0x22,0x33,0x44 -> occupancy 4, if_stallreq=1. A fifth req_ce pc=0x10 is ignored. Then id_ready=1 -> heads 0x0/0x11 … 0xC/0x44 in order, one per cycle; if_stallreq drops one cycle after the first pop.
- Flush in flight: 2 stored entries plus 1 pending, flush=1 -> id_valid=0 next cycle, occupancy 0. rdata 0xDEADBEEF arriving after the flush never appears on id_inst.
- Wrap/ordering: stream 10 fetches pc=4·i while id_ready toggles every cycle -> the id_pc sequence is 0x0…0x24 with no loss or duplicate; pointers wrap at DEPTH.
- Reset mid-operation with a full queue and pending response -> same as the reset scenario. A subsequent fetch passes through correctly.
